// File: rtl/pingpong_seq_pkg.sv
// Shared types and constants for the ping-pong buffer sequencer.
//   pp_state_e   : controller state encoding (2 bits)
//   *_DEFAULT    : default geometry of one buffer bank
//   aw_fits()    : elaboration-time check that AW can address DP words
package pingpong_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWAP  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } pp_state_e;

  localparam int DP_DEFAULT  = 768;
  localparam int AW_DEFAULT  = 10;
  localparam int RD_LAT_MAX  = 4;

  function automatic bit aw_fits(input int dp, input int aw);
    return (aw >= $clog2(dp));
  endfunction

endpackage

// File: rtl/pp_rd_addr_gen.sv
// Read-side address sweep and data-valid tracking for one bank.
//   clk, rst_n     : clock, async active-low reset
//   clr            : restart the sweep at address 0
//   issue          : a read is issued at the current address this cycle
//   addr           : current read address
//   last           : addr is the final word of the frame (DP-1)
//   vld            : buffer data valid (issue delayed by RD_LAT)
//   pipe_empty_nxt : no read will be in flight after this clock edge
import pingpong_seq_pkg::*;

module pp_rd_addr_gen #(
  parameter int DP     = DP_DEFAULT,
  parameter int AW     = AW_DEFAULT,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          issue,
  output logic [AW-1:0] addr,
  output logic          last,
  output logic          vld,
  output logic          pipe_empty_nxt
);

  // Stage 0 is the live issue; stages 1..RD_LAT are registered.
  logic [RD_LAT:1] pipe_q;
  logic [RD_LAT:0] vld_pipe;

  assign vld_pipe = {pipe_q, issue};
  assign vld      = vld_pipe[RD_LAT];
  assign last     = (addr == AW'(DP - 1));

  // Once this edge shifts, only stages 0..RD_LAT-1 can still hold reads.
  assign pipe_empty_nxt = ~|vld_pipe[RD_LAT-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (issue && !last) begin
      addr <= addr + AW'(1);
    end
  end

  // The buffer read cannot be stalled, so the pipe shifts every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= vld_pipe[RD_LAT-1:0];
  end

endmodule

// File: rtl/pingpong_seq_ctrl.sv
// Ping-pong input buffer sequencer feeding the PE array.
// Detects completed fills, swaps banks between frames, sweeps the read
// address 0..DP-1 and reports frame completion / fill overrun.
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_en               : global enable (freezes sweep, blocks swaps)
//   i_fill_done        : fill-complete level from the buffer
//   i_rd_stall         : consumer backpressure (holds read address)
//   o_switch_pingpong  : bank-select level, toggles once per swap
//   o_rd_addr          : buffer read address
//   o_rd_vld           : buffer output data valid
//   o_frame_done       : pulse when the last word of a frame has been valid
//   o_overrun          : pulse when a fill completes over an unswapped bank
//   o_busy             : controller is in SWAP, READ or DRAIN
import pingpong_seq_pkg::*;

module pingpong_seq_ctrl #(
  parameter int DP     = DP_DEFAULT,
  parameter int AW     = AW_DEFAULT,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_fill_done,
  input  logic          i_rd_stall,
  output logic          o_switch_pingpong,
  output logic [AW-1:0] o_rd_addr,
  output logic          o_rd_vld,
  output logic          o_frame_done,
  output logic          o_overrun,
  output logic          o_busy
);

  if (!aw_fits(DP, AW)) begin : g_aw_chk
    $error("pingpong_seq_ctrl: AW too narrow for DP");
  end
  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_lat_chk
    $error("pingpong_seq_ctrl: RD_LAT out of range");
  end

  pp_state_e state;
  logic      fill_done_q;
  logic      fill_edge;
  logic      fill_full;
  logic      issue;
  logic      addr_last;
  logic      pipe_empty_nxt;

  // One event per completed fill, however long the level stays high.
  assign fill_edge = i_fill_done & ~fill_done_q;
  assign issue     = (state == READ) & i_en & ~i_rd_stall;

  pp_rd_addr_gen #(
    .DP     (DP),
    .AW     (AW),
    .RD_LAT (RD_LAT)
  ) u_addr_gen (
    .clk            (i_clk),
    .rst_n          (i_rst_n),
    .clr            (state == SWAP),
    .issue          (issue),
    .addr           (o_rd_addr),
    .last           (addr_last),
    .vld            (o_rd_vld),
    .pipe_empty_nxt (pipe_empty_nxt)
  );

  // Fill tracking. In SWAP the filled bank is consumed, but an edge landing
  // in that same cycle belongs to the new fill bank and must be kept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fill_done_q <= 1'b0;
      fill_full   <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      fill_done_q <= i_fill_done;
      o_overrun   <= fill_edge & fill_full & (state != SWAP);
      if (state == SWAP)  fill_full <= fill_edge;
      else if (fill_edge) fill_full <= 1'b1;
    end
  end

  // Bank swaps happen only from IDLE or DRAIN, never mid-sweep.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state             <= IDLE;
      o_switch_pingpong <= 1'b0;
      o_frame_done      <= 1'b0;
      o_busy            <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_en && fill_full) begin
            state  <= SWAP;
            o_busy <= 1'b1;
          end
        end
        SWAP: begin
          o_switch_pingpong <= ~o_switch_pingpong;
          state             <= READ;
          o_busy            <= 1'b1;
        end
        READ: begin
          if (issue && addr_last) state <= DRAIN;
        end
        DRAIN: begin
          // Done lands on the cycle the final valid drops.
          if (pipe_empty_nxt) begin
            o_frame_done <= 1'b1;
            if (i_en && fill_full) begin
              state <= SWAP;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pingpong_seq_ctrl.sv
module tb_pingpong_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, fill, stall;
  logic       sw, vld, fd, ov, busy;
  logic [2:0] addr;
  logic       sw3, vld3, fd3, ov3, busy3;
  logic [2:0] addr3;

  int total = 0;
  int bad   = 0;
  int vld_cnt = 0, fd_cnt = 0, ov_cnt = 0;

  always #5 clk = ~clk;

  pingpong_seq_ctrl #(.DP(8), .AW(3), .RD_LAT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_fill_done(fill),
    .i_rd_stall(stall), .o_switch_pingpong(sw), .o_rd_addr(addr),
    .o_rd_vld(vld), .o_frame_done(fd), .o_overrun(ov), .o_busy(busy)
  );

  pingpong_seq_ctrl #(.DP(8), .AW(3), .RD_LAT(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_fill_done(fill),
    .i_rd_stall(stall), .o_switch_pingpong(sw3), .o_rd_addr(addr3),
    .o_rd_vld(vld3), .o_frame_done(fd3), .o_overrun(ov3), .o_busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (vld) vld_cnt++;
    if (fd)  fd_cnt++;
    if (ov)  ov_cnt++;
  endtask

  task automatic wait_fd(input string tag);
    int n = 0;
    while (!fd && n < 40) begin
      cyc();
      n++;
    end
    chk(tag, {31'd0, fd}, 1);
  endtask

  initial begin
    en = 1'b1; fill = 1'b0; stall = 1'b0; rst_n = 1'b0;

    // ---- reset state
    repeat (2) cyc();
    chk("rst_sw",    {31'd0, sw},   0);
    chk("rst_addr",  {29'd0, addr}, 0);
    chk("rst_vld",   {31'd0, vld},  0);
    chk("rst_fd",    {31'd0, fd},   0);
    chk("rst_ov",    {31'd0, ov},   0);
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst3_busy", {31'd0, busy3}, 0);
    chk("rst3_sw",   {31'd0, sw3},  0);
    #2 rst_n = 1'b1;

    // ---- A: single fill, full frame, no stall
    repeat (4) cyc();
    fill = 1'b1; cyc(); fill = 1'b0;              // edge 5
    chk("a_busy5", {31'd0, busy}, 0);
    cyc();                                        // edge 6: SWAP
    chk("a_busy6", {31'd0, busy}, 1);
    chk("a_sw6",   {31'd0, sw},   0);
    cyc();                                        // edge 7: READ addr 0
    chk("a_sw7",   {31'd0, sw},   1);
    chk("a_vld7",  {31'd0, vld},  0);
    for (int k = 0; k < 8; k++) begin
      chk("a_addr", {29'd0, addr}, k);
      cyc();
      chk("a_vld",  {31'd0, vld}, 1);
      chk("a_fd",   {31'd0, fd},  0);
    end
    chk("a3_vld15", {31'd0, vld3}, 1);
    cyc();                                        // edge 16
    chk("a_fd16",   {31'd0, fd},   1);
    chk("a_vld16",  {31'd0, vld},  0);
    chk("a_busy16", {31'd0, busy}, 0);
    chk("a3_fd16",  {31'd0, fd3},  0);
    chk("a3_vld16", {31'd0, vld3}, 1);
    cyc();                                        // edge 17
    chk("a_fd17",   {31'd0, fd},   0);
    chk("a3_fd17",  {31'd0, fd3},  0);
    chk("a3_vld17", {31'd0, vld3}, 1);
    cyc();                                        // edge 18
    chk("a3_fd18",  {31'd0, fd3},  1);
    chk("a3_vld18", {31'd0, vld3}, 0);

    // ---- B: stall while addr=3
    vld_cnt = 0; fd_cnt = 0;
    fill = 1'b1; cyc(); fill = 1'b0;
    cyc(); cyc();
    chk("b_sw", {31'd0, sw}, 0);
    cyc(); cyc(); cyc();
    chk("b_addr3", {29'd0, addr}, 3);
    chk("b_trail", {31'd0, vld},  1);
    stall = 1'b1;
    repeat (3) begin
      cyc();
      chk("b_hold", {29'd0, addr}, 3);
      chk("b_vlow", {31'd0, vld},  0);
    end
    stall = 1'b0;
    cyc();
    chk("b_addr4", {29'd0, addr}, 4);
    wait_fd("b_fd");
    cyc();
    chk("b_vcnt",  vld_cnt, 8);
    chk("b_fdcnt", fd_cnt,  1);

    // ---- C: second fill mid-READ, back-to-back swap
    fill = 1'b1; cyc(); fill = 1'b0;
    cyc(); cyc();
    chk("c_sw1",   {31'd0, sw},   1);
    chk("c_addr0", {29'd0, addr}, 0);
    cyc(); cyc();
    fill = 1'b1; cyc(); fill = 1'b0;
    chk("c_ov",    {31'd0, ov},   0);
    chk("c_swmid", {31'd0, sw},   1);
    wait_fd("c_fd1");
    chk("c_busyfd", {31'd0, busy}, 1);
    chk("c_swfd",   {31'd0, sw},   1);
    cyc();
    chk("c_sw0",    {31'd0, sw},   0);
    chk("c_naddr",  {29'd0, addr}, 0);
    chk("c_busy",   {31'd0, busy}, 1);
    wait_fd("c_fd2");
    cyc();

    // ---- D: two fills in one READ -> one overrun, one swap
    ov_cnt = 0;
    fill = 1'b1; cyc(); fill = 1'b0;
    cyc(); cyc(); cyc();
    fill = 1'b1; cyc(); fill = 1'b0;
    chk("d_ov1", {31'd0, ov}, 0);
    cyc();
    fill = 1'b1; cyc(); fill = 1'b0;
    chk("d_ov2", {31'd0, ov}, 1);
    cyc();
    chk("d_ovclr", {31'd0, ov}, 0);
    wait_fd("d_fd1");
    cyc(); cyc();
    chk("d_sw", {31'd0, sw}, 0);
    wait_fd("d_fd2");
    repeat (4) cyc();
    chk("d_idle",  {31'd0, busy}, 0);
    chk("d_swfin", {31'd0, sw},   0);
    chk("d_ovcnt", ov_cnt, 1);

    // ---- E: fill level held 5 cycles -> one fill
    ov_cnt = 0;
    fill = 1'b1; repeat (5) cyc(); fill = 1'b0;
    wait_fd("e_fd");
    repeat (4) cyc();
    chk("e_ovcnt", ov_cnt, 0);
    chk("e_sw",    {31'd0, sw},   1);
    chk("e_idle",  {31'd0, busy}, 0);

    // ---- F: async reset mid-frame
    fill = 1'b1; cyc(); fill = 1'b0;
    begin
      int n = 0;
      while (addr != 3'd5 && n < 20) begin
        cyc();
        n++;
      end
    end
    chk("f_reach", {29'd0, addr}, 5);
    chk("f_busy",  {31'd0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("f_rsw",   {31'd0, sw},   0);
    chk("f_raddr", {29'd0, addr}, 0);
    chk("f_rvld",  {31'd0, vld},  0);
    chk("f_rfd",   {31'd0, fd},   0);
    chk("f_rov",   {31'd0, ov},   0);
    chk("f_rbusy", {31'd0, busy}, 0);
    chk("f3_rbusy", {31'd0, busy3}, 0);
    chk("f3_raddr", {29'd0, addr3}, 0);
    #3 rst_n = 1'b1;
    repeat (6) cyc();
    chk("f_idle",  {31'd0, busy}, 0);
    chk("f_addr",  {29'd0, addr}, 0);
    chk("f_sw",    {31'd0, sw},   0);
    chk("f_vld",   {31'd0, vld},  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pingpong_seq_ctrl.md
Name: pingpong_seq_ctrl

Overview:
- Single-clock sequencer for the ping-pong input buffer that feeds the PE array.
- Watches the buffer's fill-complete indication and decides when to swap banks, then drives the `i_switch_pingpong` level.
- Generates the read-address sweep 0..DP-1 on the output side, with a valid strobe aligned to buffer read latency and consumer backpressure.
- Reports frame completion and fill overrun to the upstream loader and the PE controller.

Parameters:
- DP, 768, words per bank; one frame = DP reads.
- AW, 10, address width; requires 2^AW >= DP.
- RD_LAT, 1, cycles from address issue to buffer data valid; legal range 1..4.

Ports:
- i_clk  in  1  sole clock; also used to clock the buffer's input and output sides.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  global enable; low freezes sweep and blocks swaps.
- i_fill_done  in  1  buffer fill-complete level (o_pl_buffer_ready); edge-detected internally.
- i_rd_stall  in  1  consumer backpressure; high holds the read address.
- o_switch_pingpong  out  1  bank-select level to the buffer; toggles once per swap.
- o_rd_addr  out  AW  read address to the buffer (i_conv_addr).
- o_rd_vld  out  1  buffer output data valid this cycle.
- o_frame_done  out  1  one-cycle pulse after the last word of a frame is valid.
- o_overrun  out  1  one-cycle pulse when a fill completes while the filled bank is still unswapped.
- o_busy  out  1  high in SWAP, READ or DRAIN.

Behaviour:
- Reset values (async assert, synchronous deassert use):
  - state=IDLE, o_switch_pingpong=0, o_rd_addr=0.
  - o_rd_vld=0, o_frame_done=0, o_overrun=0, o_busy=0.
  - fill_full=0, valid pipe cleared, edge-detect register=0.
- fill_edge = i_fill_done & ~i_fill_done_q. This is one event per completed fill, even if the level stays high several cycles.
- fill_full:
  - Set on fill_edge.
  - Cleared in the SWAP cycle.
  - In the SWAP cycle, fill_full <= fill_edge, so a simultaneous edge is kept for the new fill bank.
- o_overrun pulses when fill_edge arrives while fill_full=1 outside SWAP. fill_full stays 1 and the data is not counted twice.
- IDLE: if i_en & fill_full -> SWAP.
- SWAP, one cycle:
  - Toggle o_switch_pingpong and clear fill_full.
  - Set o_rd_addr=0, then -> READ.
  - Swap-to-first-issue latency is 1 cycle.
- READ:
  - issue = i_en & ~i_rd_stall.
  - On issue: if o_rd_addr==DP-1 -> DRAIN; else o_rd_addr+1.
  - No issue: o_rd_addr holds.
  - Exactly DP issues per frame; no wrap past DP-1.
- Valid pipe:
  - RD_LAT-deep shift register of issue; o_rd_vld is its tail.
  - The pipe advances every cycle regardless of stall: the buffer read is not stallable, so the consumer must accept in-flight data.
- DRAIN:
  - Wait until the valid pipe is empty, i.e. RD_LAT cycles after the last issue.
  - Then pulse o_frame_done in the same cycle as the last o_rd_vld falls. Exact timing: o_frame_done is asserted in the first cycle where the pipe is empty.
  - Next: -> SWAP if i_en & fill_full, else -> IDLE.
  - Back-to-back frames therefore have a gap of 1 (SWAP) + RD_LAT cycles.
- Swaps occur only from IDLE or DRAIN. A bank is never switched while it is being read.
- i_en low in IDLE or DRAIN blocks the transition into SWAP; DRAIN itself still completes.
- fill_edge and overrun detection remain active in all states.
- Reset mid-frame aborts the sweep immediately. o_switch_pingpong returns to 0; the buffer must be reset together with the controller.
- o_busy = state != IDLE.

Decomposition:
- Package pingpong_seq_pkg holds:
  - state enum {IDLE, SWAP, READ, DRAIN}, 2-bit encoding.
  - constants DP_DEFAULT=768, AW_DEFAULT=10, RD_LAT_MAX=4.
  - clog2-based AW check function.
- One sub-module, pp_rd_addr_gen, owns:
  - the address counter: clear, advance, and last-flag at DP-1.
  - the RD_LAT valid shift register, which outputs addr, last and vld.
- The FSM, fill_full, edge detect and overrun logic stay in the top.

Test Plan (DP=8, AW=3, RD_LAT=1 unless stated):
- Reset, then a single fill_done pulse at cycle 5, no stall -> SWAP at cycle 6, o_switch_pingpong 0->1. o_rd_addr runs 0..7 over cycles 7..14. o_rd_vld is high cycles 8..15. o_frame_done pulses at cycle 16, then IDLE.
- i_rd_stall high for 3 cycles while o_rd_addr=3 -> address holds at 3. o_rd_vld sees exactly one trailing valid and then 3 low cycles. Total valids = 8 and o_frame_done fires once.
- Second fill_done arrives mid-READ -> no swap until DRAIN ends. o_switch_pingpong toggles 1->0 immediately after o_frame_done with no IDLE visit, and a new sweep starts from addr 0.
- Two fill_done edges during one READ -> o_overrun pulses once, on the second edge. Exactly one subsequent swap occurs.
- i_fill_done held high 5 cycles -> counts as one fill. No o_overrun.
- Async reset asserted at o_rd_addr=5 -> all outputs are 0 immediately, without waiting for a clock edge. After release with no fill, the block stays IDLE. RD_LAT=3 variant: o_frame_done arrives 3 cycles after the last issue.
